// File: rtl/multi_issue_decoder.sv
// Multi-issue RV32I decoder: buffers one fetch bundle, decodes every lane and
// issues the oldest pending lanes as hazard-free groups through a registered output stage.
module multi_issue_decoder #(
    parameter int LANES     = 2,
    parameter int MEM_PORTS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*4-1:0]    out_alu_opr,
    output logic [LANES*5-1:0]    out_rd,
    output logic [LANES*5-1:0]    out_rs1,
    output logic [LANES*5-1:0]    out_rs2,
    output logic [LANES*32-1:0]   out_imm,
    output logic [LANES*3-1:0]    out_mem_size,
    output logic [LANES-1:0]      out_reg_write_en,
    output logic [LANES-1:0]      out_rs2_en,
    output logic [LANES-1:0]      out_branch_en,
    output logic [LANES-1:0]      out_mem_read_en,
    output logic [LANES-1:0]      out_mem_write_en,
    output logic [LANES-1:0]      out_illegal
);

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  msize;
        logic        we;
        logic        rs2_en;
        logic        br;
        logic        mrd;
        logic        mwr;
        logic        ill;
    } dec_t;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] a;
        case (f3)
            3'd0:    a = 4'b0000;
            3'd1:    a = 4'b0010;
            3'd2:    a = 4'b1000;
            3'd3:    a = 4'b1001;
            3'd4:    a = 4'b0011;
            3'd5:    a = 4'b0100;
            3'd6:    a = 4'b0110;
            3'd7:    a = 4'b0111;
            default: a = 4'b0000;
        endcase
        return a;
    endfunction

    function automatic dec_t decode_lane(input logic [31:0] inst);
        dec_t        d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm;
        d     = '0;
        f3    = inst[14:12];
        f7    = inst[31:25];
        i_imm = {{20{inst[31]}}, inst[31:20]};
        case (inst[6:0])
            7'b0110011: begin
                d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
                d.we = 1'b1; d.rs2_en = 1'b1;
                case (f7)
                    7'b0000000: d.alu = f3_alu(f3);
                    7'b0100000: begin
                        case (f3)
                            3'd0:    d.alu = 4'b0001;
                            3'd5:    d.alu = 4'b0101;
                            default: d.ill = 1'b1;
                        endcase
                    end
                    default: d.ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.we = 1'b1;
                case (f3)
                    3'd1: begin
                        d.alu = 4'b0010;
                        d.imm = {27'd0, inst[24:20]};
                        d.ill = (f7 != 7'b0000000);
                    end
                    3'd5: begin
                        d.alu = (f7 == 7'b0100000) ? 4'b0101 : 4'b0100;
                        d.imm = {27'd0, inst[24:20]};
                        d.ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                    default: begin
                        d.alu = f3_alu(f3);
                        d.imm = i_imm;
                    end
                endcase
            end
            7'b0000011: begin
                d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.imm = i_imm;
                d.we = 1'b1; d.mrd = 1'b1; d.msize = f3;
                case (f3)
                    3'd3, 3'd6, 3'd7: d.ill = 1'b1;
                    default:          d.ill = 1'b0;
                endcase
            end
            7'b0100011: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.rs2_en = 1'b1; d.mwr = 1'b1; d.msize = f3;
                d.ill = (f3 > 3'd2);
            end
            7'b1100011: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.alu = 4'b0001;
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.rs2_en = 1'b1; d.br = 1'b1;
                case (f3)
                    3'd2, 3'd3: d.ill = 1'b1;
                    default:    d.ill = 1'b0;
                endcase
            end
            default: d.ill = 1'b1;
        endcase
        // An illegal lane carries nothing but its illegal flag.
        if (d.ill) begin
            d     = '0;
            d.ill = 1'b1;
        end else begin
            d.ill = 1'b0;
        end
        return d;
    endfunction

    logic [LANES*32-1:0] bundle_r;
    logic [LANES-1:0]    pend_r;
    logic [LANES-1:0]    grp_s;
    logic                form_s;
    logic                accept_s;
    dec_t                dec_s  [LANES];
    dec_t                gate_s [LANES];

    // Per-lane decode of the buffered bundle, gated down to the lanes of the forming group.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            dec_s[l]  = decode_lane(bundle_r[32*l +: 32]);
            gate_s[l] = grp_s[l] ? dec_s[l] : '0;
        end
    end

    // Group formation: oldest pending lanes in order until a hazard, port limit or control stop.
    always_comb begin
        logic        stop_v;
        logic        started_v;
        logic        raw_v;
        logic        waw_v;
        logic        mem_v;
        logic [3:0]  mem_cnt_v;
        logic [31:0] wmask_v;
        grp_s     = '0;
        stop_v    = 1'b0;
        started_v = 1'b0;
        raw_v     = 1'b0;
        waw_v     = 1'b0;
        mem_v     = 1'b0;
        mem_cnt_v = 4'd0;
        wmask_v   = 32'd0;
        for (int j = 0; j < LANES; j++) begin
            if (stop_v || !pend_r[j]) begin
                stop_v = stop_v || started_v;
            end else begin
                // x0 is never entered into wmask_v, so unused rs fields (0) cannot match.
                raw_v = wmask_v[dec_s[j].rs1] || (dec_s[j].rs2_en && wmask_v[dec_s[j].rs2]);
                waw_v = dec_s[j].we && wmask_v[dec_s[j].rd];
                mem_v = dec_s[j].mrd || dec_s[j].mwr;
                if (raw_v || waw_v || (mem_v && (mem_cnt_v == 4'(MEM_PORTS)))) begin
                    stop_v = 1'b1;
                end else begin
                    grp_s[j]  = 1'b1;
                    started_v = 1'b1;
                    if (dec_s[j].we && (dec_s[j].rd != 5'd0)) begin
                        wmask_v[dec_s[j].rd] = 1'b1;
                    end else begin
                        wmask_v = wmask_v;
                    end
                    mem_cnt_v = mem_v ? mem_cnt_v + 4'd1 : mem_cnt_v;
                    stop_v    = dec_s[j].br || dec_s[j].ill;
                end
            end
        end
    end

    assign form_s   = (pend_r != '0) && (!out_valid || out_ready);
    assign in_ready = !flush && ((pend_r == '0) || (form_s && (grp_s == pend_r)));
    assign accept_s = in_valid && in_ready;

    // Bundle buffer, pending mask and registered issue-group outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_r         <= '0;
            pend_r           <= '0;
            out_valid        <= 1'b0;
            out_lane_valid   <= '0;
            out_alu_opr      <= '0;
            out_rd           <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_imm          <= '0;
            out_mem_size     <= '0;
            out_reg_write_en <= '0;
            out_rs2_en       <= '0;
            out_branch_en    <= '0;
            out_mem_read_en  <= '0;
            out_mem_write_en <= '0;
            out_illegal      <= '0;
        end else if (flush) begin
            pend_r         <= '0;
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
        end else begin
            if (form_s) begin
                out_valid      <= 1'b1;
                out_lane_valid <= grp_s;
                for (int l = 0; l < LANES; l++) begin
                    out_alu_opr[4*l +: 4]   <= gate_s[l].alu;
                    out_rd[5*l +: 5]        <= gate_s[l].rd;
                    out_rs1[5*l +: 5]       <= gate_s[l].rs1;
                    out_rs2[5*l +: 5]       <= gate_s[l].rs2;
                    out_imm[32*l +: 32]     <= gate_s[l].imm;
                    out_mem_size[3*l +: 3]  <= gate_s[l].msize;
                    out_reg_write_en[l]     <= gate_s[l].we;
                    out_rs2_en[l]           <= gate_s[l].rs2_en;
                    out_branch_en[l]        <= gate_s[l].br;
                    out_mem_read_en[l]      <= gate_s[l].mrd;
                    out_mem_write_en[l]     <= gate_s[l].mwr;
                    out_illegal[l]          <= gate_s[l].ill;
                end
            end else if (out_ready) begin
                out_valid      <= 1'b0;
                out_lane_valid <= '0;
            end else begin
                out_valid <= out_valid;
            end
            if (accept_s) begin
                bundle_r <= in_inst;
                pend_r   <= '1;
            end else if (form_s) begin
                pend_r <= pend_r & ~grp_s;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

endmodule

// File: tb/tb_multi_issue_decoder.sv
// Directed bench for multi_issue_decoder (LANES=2, MEM_PORTS=1): single-instruction
// decode table plus hand-written split, stall, flush and reset sequences.
module tb_multi_issue_decoder;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_inst;
    logic [1:0]  out_lane_valid, out_reg_write_en, out_rs2_en, out_branch_en;
    logic [1:0]  out_mem_read_en, out_mem_write_en, out_illegal;
    logic [7:0]  out_alu_opr;
    logic [9:0]  out_rd, out_rs1, out_rs2;
    logic [63:0] out_imm;
    logic [5:0]  out_mem_size;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_issue_decoder #(.LANES(2), .MEM_PORTS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_alu_opr(out_alu_opr), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_mem_size(out_mem_size),
        .out_reg_write_en(out_reg_write_en), .out_rs2_en(out_rs2_en),
        .out_branch_en(out_branch_en), .out_mem_read_en(out_mem_read_en),
        .out_mem_write_en(out_mem_write_en), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  lv;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  ms;
        logic [5:0]  fl;   // {we, rs2_en, br, mrd, mwr, ill}
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags(input int l);
        return {out_reg_write_en[l], out_rs2_en[l], out_branch_en[l],
                out_mem_read_en[l], out_mem_write_en[l], out_illegal[l]};
    endfunction

    task automatic send(input logic [63:0] bundle);
        in_inst  = bundle;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_group(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (!ok) begin
                @(negedge clk);
                ok = out_valid;
            end
        end
        check({name, "_timeout"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (!ok) begin
                @(negedge clk);
                ok = !out_valid && in_ready;
            end
        end
        check({name, "_drain"}, {63'd0, ok}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h00700293, 2'b11, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h00000007, 3'b000, 6'b100000};
        vecs[1]  = '{32'h002081B3, 2'b11, 4'b0000, 5'd3, 5'd1, 5'd2, 32'h00000000, 3'b000, 6'b110000};
        vecs[2]  = '{32'h402081B3, 2'b11, 4'b0001, 5'd3, 5'd1, 5'd2, 32'h00000000, 3'b000, 6'b110000};
        vecs[3]  = '{32'h4020D1B3, 2'b11, 4'b0101, 5'd3, 5'd1, 5'd2, 32'h00000000, 3'b000, 6'b110000};
        vecs[4]  = '{32'h0020B1B3, 2'b11, 4'b1001, 5'd3, 5'd1, 5'd2, 32'h00000000, 3'b000, 6'b110000};
        vecs[5]  = '{32'h4030D393, 2'b11, 4'b0101, 5'd7, 5'd1, 5'd0, 32'h00000003, 3'b000, 6'b100000};
        vecs[6]  = '{32'hFFF08293, 2'b11, 4'b0000, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 3'b000, 6'b100000};
        vecs[7]  = '{32'h0040A303, 2'b11, 4'b0000, 5'd6, 5'd1, 5'd0, 32'h00000004, 3'b010, 6'b100100};
        vecs[8]  = '{32'h0020A423, 2'b11, 4'b0000, 5'd0, 5'd1, 5'd2, 32'h00000008, 3'b010, 6'b010010};
        vecs[9]  = '{32'hFE208EE3, 2'b01, 4'b0001, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 3'b000, 6'b011000};
        vecs[10] = '{32'hFFFFFFFF, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};
        vecs[11] = '{32'h0040B303, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};
        vecs[12] = '{32'h0020B423, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};
        vecs[13] = '{32'h022081B3, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};
        vecs[14] = '{32'h402091B3, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};
        vecs[15] = '{32'h01F09393, 2'b11, 4'b0010, 5'd7, 5'd1, 5'd0, 32'h0000001F, 3'b000, 6'b100000};
        vecs[16] = '{32'hFF80C303, 2'b11, 4'b0000, 5'd6, 5'd1, 5'd0, 32'hFFFFFFF8, 3'b100, 6'b100100};
        vecs[17] = '{32'hFE208FA3, 2'b11, 4'b0000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFF, 3'b000, 6'b010010};
        vecs[18] = '{32'h0020A063, 2'b01, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 6'b000001};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = 64'd0;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_lane_valid", {62'd0, out_lane_valid}, 64'd0);
        check("rst_imm", out_imm, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Decode table: lane 0 under test, lane 1 is addi x0,x0,0.
        for (int i = 0; i < 19; i++) begin
            send({32'h00000013, vecs[i].inst});
            wait_group($sformatf("v%0d", i));
            check($sformatf("v%0d_lv", i),  {62'd0, out_lane_valid}, {62'd0, vecs[i].lv});
            check($sformatf("v%0d_alu", i), {60'd0, out_alu_opr[3:0]}, {60'd0, vecs[i].alu});
            check($sformatf("v%0d_rd", i),  {59'd0, out_rd[4:0]}, {59'd0, vecs[i].rd});
            check($sformatf("v%0d_rs1", i), {59'd0, out_rs1[4:0]}, {59'd0, vecs[i].rs1});
            check($sformatf("v%0d_rs2", i), {59'd0, out_rs2[4:0]}, {59'd0, vecs[i].rs2});
            check($sformatf("v%0d_imm", i), {32'd0, out_imm[31:0]}, {32'd0, vecs[i].imm});
            check($sformatf("v%0d_ms", i),  {61'd0, out_mem_size[2:0]}, {61'd0, vecs[i].ms});
            check($sformatf("v%0d_fl", i),  {58'd0, flags(0)}, {58'd0, vecs[i].fl});
            drain($sformatf("v%0d", i));
        end

        // Hazard-free bundle: one group, one-cycle latency.
        send({32'h002081B3, 32'h00700293});
        @(negedge clk);
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_valid", {63'd0, out_valid}, 64'd1);
        check("pair_lv", {62'd0, out_lane_valid}, 64'd3);
        check("pair_imm0", {32'd0, out_imm[31:0]}, 64'd7);
        check("pair_alu0", {60'd0, out_alu_opr[3:0]}, 64'd0);
        check("pair_rs2en1", {63'd0, out_rs2_en[1]}, 64'd1);
        @(negedge clk);
        check("pair_single", {63'd0, out_valid}, 64'd0);
        drain("pair");

        // RAW split.
        send({32'h00118233, 32'h002081B3});
        @(negedge clk);
        check("raw_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("raw_g1_lv", {62'd0, out_lane_valid}, 64'd1);
        @(negedge clk);
        check("raw_g2_valid", {63'd0, out_valid}, 64'd1);
        check("raw_g2_lv", {62'd0, out_lane_valid}, 64'd2);
        check("raw_g2_rd1", {59'd0, out_rd[9:5]}, 64'd4);
        check("raw_g2_lane0_rd", {59'd0, out_rd[4:0]}, 64'd0);
        drain("raw");

        // Memory-port split.
        send({32'h0020A423, 32'h0040A303});
        wait_group("mem1");
        check("mem_g1_lv", {62'd0, out_lane_valid}, 64'd1);
        check("mem_g1_ms", {61'd0, out_mem_size[2:0]}, 64'd2);
        check("mem_g1_imm", {32'd0, out_imm[31:0]}, 64'd4);
        @(negedge clk);
        check("mem_g2_lv", {62'd0, out_lane_valid}, 64'd2);
        check("mem_g2_imm", {32'd0, out_imm[63:32]}, 64'd8);
        check("mem_g2_mwr", {63'd0, out_mem_write_en[1]}, 64'd1);
        check("mem_g2_we", {63'd0, out_reg_write_en[1]}, 64'd0);
        drain("mem");

        // Illegal lane closes the group.
        send({32'h002081B3, 32'hFFFFFFFF});
        wait_group("ill1");
        check("ill_g1_lv", {62'd0, out_lane_valid}, 64'd1);
        check("ill_g1_fl", {58'd0, flags(0)}, 64'h01);
        @(negedge clk);
        check("ill_g2_lv", {62'd0, out_lane_valid}, 64'd2);
        check("ill_g2_fl", {58'd0, flags(1)}, 64'h30);
        drain("ill");

        // Back-pressure then flush.
        out_ready = 1'b0;
        send({32'h00118233, 32'h002081B3});
        wait_group("stall");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), {63'd0, out_valid}, 64'd1);
            check($sformatf("stall%0d_lv", c), {62'd0, out_lane_valid}, 64'd1);
            check($sformatf("stall%0d_rd0", c), {59'd0, out_rd[4:0]}, 64'd3);
            check($sformatf("stall%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
        end
        flush = 1'b1;
        #1 check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_lv", {62'd0, out_lane_valid}, 64'd0);
        check("flush_pend", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("flush_quiet%0d", c), {63'd0, out_valid}, 64'd0);
        end

        // Reset between the two RAW groups.
        send({32'h00118233, 32'h002081B3});
        wait_group("rstmid");
        check("rstmid_g1_lv", {62'd0, out_lane_valid}, 64'd1);
        rst = 1'b1;
        #2;
        check("rstmid_async_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid%0d_valid", c), {63'd0, out_valid}, 64'd0);
            check($sformatf("rstmid%0d_lv", c), {62'd0, out_lane_valid}, 64'd0);
            check($sformatf("rstmid%0d_rd", c), {54'd0, out_rd}, 64'd0);
            check($sformatf("rstmid%0d_in_ready", c), {63'd0, in_ready}, 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
